button_debounce: RTL and testbench

//  Input-side counterpart to the LED output path: conditions a mechanical pushbutton into clean clk_12mhz-domain events.
//  - Synchronises the raw pin (2 flops), filters bounce with a stability counter, then emits a debounced level and 1-cycle press/release pulses.
//  - Optionally emits a 1-cycle long-press pulse.
//  - Sits between a top-level pad and any control logic (LED modes, ML-demo triggers).

---
 rtl/button_debounce.sv | 188 ++++++++++++++++++
 tb/tb_button_debounce.sv | 137 +++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - pushbutton synchroniser, debounce FSM and press/release/long-press strobes (optional feature macro: BTN_LONGPRESS_EN)
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned LONG_CYCLES     = 12000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk_12mhz,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned      CNT_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    // Pad level seen while the button is not pressed.
    localparam logic             RELEASED_LVL = ACTIVE_LOW;

    // Parameter sanity: a one-cycle filter is meaningless and a long press must outlast the filter.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("button_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             pressed_s;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Two-flop synchroniser; resets to the released pad level so reset never looks like a press.
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RELEASED_LVL;
            sync2_q <= RELEASED_LVL;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Debounce FSM: any disagreement during a wait state throws the partial count away.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pressed_s) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (!pressed_s) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_RELEASE_WAIT: begin
                if (pressed_s) begin
                    // Release bounce: level never dropped, so no strobe either way.
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM state, filter counter and registered outputs.
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BTN_LONGPRESS_EN
    localparam int unsigned       LONG_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

    logic [LONG_W-1:0] long_cnt_q;
    logic [LONG_W-1:0] long_cnt_d;
    logic              long_q;
    logic              long_d;
    logic              hold_tick;

    // Counts only while settled in PRESSED; a release bounce pauses rather than clears it.
    assign hold_tick = (state_q == S_PRESSED) && pressed_s;

    // Long-press counter: cleared on a fresh accepted press, fires once, then parks above the fire value.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_d     = 1'b0;
        if (press_d) begin
            long_cnt_d = '0;
        end else if (hold_tick) begin
            if (long_cnt_q == LONG_LAST) begin
                long_d     = 1'b1;
                long_cnt_d = LONG_SAT;
            end else if (long_cnt_q < LONG_LAST) begin
                long_cnt_d = long_cnt_q + LONG_ONE;
            end
        end
    end

    // Long-press counter and strobe registers.
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce (D=8, LONG=32, active-low pad)
module tb_button_debounce;

    logic clk_12mhz = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BTN_LONGPRESS_EN
    localparam logic LP_EN = 1'b1;
`else
    localparam logic LP_EN = 1'b0;
`endif

    button_debounce #(
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (32),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk_12mhz     (clk_12mhz),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    task automatic step();
        @(posedge clk_12mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic lvl, input logic pp,
                              input logic rp, input logic lp);
        chk({tag, ".btn_level"}, btn_level, lvl);
        chk({tag, ".press_pulse"}, press_pulse, pp);
        chk({tag, ".release_pulse"}, release_pulse, rp);
        chk({tag, ".long_press"}, long_press, lp);
    endtask

    task automatic hold(input int n, input string tag, input logic lvl, input logic pp,
                        input logic rp, input logic lp);
        for (int i = 0; i < n; i++) begin
            step();
            expect_out(tag, lvl, pp, rp, lp);
        end
    endtask

    initial begin
        // 1: reset with button held, press accepted on edge 10 after release
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        #1;
        hold(3, "reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        hold(9, "t1_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1, "t1_press", 1'b1, 1'b1, 1'b0, 1'b0);

        // 5: long press fires once, 32 cycles after the press strobe
        hold(31, "t5_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        hold(1, "t5_long", 1'b1, 1'b0, 1'b0, LP_EN);
        hold(8, "t5_sat", 1'b1, 1'b0, 1'b0, 1'b0);

        // 2: clean release, then clean press held 20 cycles, then release
        btn_raw = 1'b1;
        hold(9, "t2_rel_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        hold(1, "t2_rel", 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1, "t2_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b0;
        hold(9, "t2_prs_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1, "t2_prs", 1'b1, 1'b1, 1'b0, 1'b0);
        hold(10, "t2_held", 1'b1, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b1;
        hold(9, "t2_rel2_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        hold(1, "t2_rel2", 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1, "t2_idle2", 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: bounce every 3 cycles x6, then settle pressed
        for (int j = 0; j < 6; j++) begin
            btn_raw = ~btn_raw;
            hold(3, "t3_bounce", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        btn_raw = 1'b0;
        hold(9, "t3_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1, "t3_press", 1'b1, 1'b1, 1'b0, 1'b0);
        hold(1, "t3_held", 1'b1, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b1;
        hold(9, "t3_rel_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        hold(1, "t3_rel", 1'b0, 1'b0, 1'b1, 1'b0);

        // 4: 5-cycle glitch rejected
        btn_raw = 1'b0;
        hold(5, "t4_glitch", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b1;
        hold(10, "t4_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // release bounce: short release keeps level high, no strobes
        btn_raw = 1'b0;
        hold(9, "rb_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1, "rb_press", 1'b1, 1'b1, 1'b0, 1'b0);
        btn_raw = 1'b1;
        hold(4, "rb_short_rel", 1'b1, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b0;
        hold(10, "rb_back", 1'b1, 1'b0, 1'b0, 1'b0);

        // 6: asynchronous reset while pressed, then release during reset
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("t6_async", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b1;
        hold(3, "t6_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        hold(15, "t6_after", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
